pamiec_data_str: RTL
====================

// Module: pamiec_data_str
// PURPOSE
//  Parametrised paged data memory for the single-cycle CPU: 2^STRONY_WIDTH pages of 2^ADDR_WIDTH words.
//  The top two addresses of every page are control registers: page select and status/command.
//  Adds a background page-clear engine that fills the current page with FILL, and a busy flag.
//  Sits on the CPU data bus, in place of the fixed 8-bit/16-page memory.
// PARAMETERS
//  ADDR_WIDTH    8     CPU address width; page size = 2^ADDR_WIDTH words
//  DATA_WIDTH    8     data word width; must be > STRONY_WIDTH
//  STRONY_WIDTH  4     page-select width; page count = 2^STRONY_WIDTH
//  FILL          0     DATA_WIDTH value written by the page-clear engine
// PORTS
//  clk     in   1             clock; all state updates on rising edge
//  rst     in   1             reset, asynchronous, active-low
//  wr_mem  in   1             write strobe for the current cycle
//  adres   in   ADDR_WIDTH    CPU address within the current page
//  dane    in   DATA_WIDTH    write data
//  out     out  DATA_WIDTH    read data, combinational
//  strona  out  STRONY_WIDTH  current page register
//  zajety  out  1             page-clear engine active
// BEHAVIOUR
//  Address map, with TOP = 2^ADDR_WIDTH-1:
//   - TOP = page register (ADR_STRONA).
//   - TOP-1 = status/command (ADR_STATUS).
//   - 0..TOP-2 = RAM at physical address {strona, adres}.
//   - Physical words TOP-1 and TOP of every page are unreachable.
//  Reset (rst=0, async):
//   - strona=0, zajety=0, FSM=BEZCZYNNY, clear counter=0.
//   - RAM contents are not reset.
//  Read path (combinational, zero latency, evaluated in priority order):
//   - adres=TOP: wr_mem=1 -> out=dane (write-through); wr_mem=0 -> out={0, strona}.
//   - adres=TOP-1: out = {zajety, 0..., page_clr}. Page_clr is in bits [STRONY_WIDTH-1:0].
//     The status value is pre-edge state; dane is never forwarded at this address.
//   - RAM address, wr_mem=1, zajety=0: out=dane (write-through). The word is stored at the edge.
//   - RAM address otherwise: out = mem[{strona, adres}].
//  Page register:
//   - wr_mem=1 and adres=TOP -> strona <= dane[STRONY_WIDTH-1:0] at the edge.
//   - Accepted in either FSM state.
//  FSM stan_t {BEZCZYNNY, CZYSZCZENIE}:
//   - BEZCZYNNY -> CZYSZCZENIE when wr_mem=1, adres=TOP-1 and dane[0]=1.
//     On that edge: latch page_clr=strona and licznik=0.
//   - CZYSZCZENIE, each cycle: mem[{page_clr, licznik}] <= FILL, then licznik++.
//   - After the write at licznik=TOP-2: -> BEZCZYNNY, licznik=0.
//   - zajety=1 exactly while in CZYSZCZENIE: TOP-1 cycles. For the defaults that is 254 cycles.
//  While zajety=1:
//   - CPU RAM writes are dropped; out shows stored data, not dane.
//   - A start command is ignored.
//   - A page change does not retarget the clear; page_clr stays latched.
//   - Reads of any page work. Words already cleared read FILL.
//  Simultaneous events: a start command and a page write cannot coincide, because they use different addresses.
//  Reset mid-clear aborts immediately. The page stays partially cleared and the engine restarts only on a new command.
//  Widths: licznik is ADDR_WIDTH bits. Its terminal compare is against TOP-2, so it never reaches the register addresses.
// STRUCTURE
//  Package pamiec_pkg holds:
//   - typedef enum logic stan_t {BEZCZYNNY, CZYSZCZENIE};
//   - functions adr_strona(aw) and adr_status(aw) returning TOP and TOP-1.
//  Sub-module ram_strony #(AW, DW): synchronous write port, asynchronous read port.
//   - The write port is muxed between the CPU and the clear engine by zajety.
//  Top level holds the page register, the FSM, licznik, page_clr and the out mux.
// TESTING
//  1. rst pulse low mid-cycle -> strona=0, zajety=0 immediately; read TOP -> 0x00, read TOP-1 -> 0x00.
//  2. Page 0: write 100=0xAA. Set page 5, write 100=0x55. Set page 0, read 100 -> 0xAA.
//     Then read TOP -> 0x00.
//  3. Write-through: adres=80, dane=0x77, wr_mem=1 -> out=0x77 before the edge.
//     Following read of 80 -> 0x77.
//  4. Clear (FILL=0): page 3 with 0=0x11 and 253=0x22. Write TOP-1 with 0x01.
//     -> zajety high for exactly 254 cycles, status=0x83 during the clear.
//     -> afterwards 0 and 253 read 0x00; page 5 word 100 is still 0x55.
//  5. During clear:
//     - write 10=0x99 on page 3 -> out≠0x99, and word 10 reads 0x00 after the clear.
//     - set page 5 mid-clear -> page 5 is untouched.
//     - a second start is ignored: busy stays 254 cycles total.
//  6. rst low at clear cycle 100 -> zajety=0 at once; page 3 word 200 keeps its old value, word 50 reads 0x00.
//  Repeat scenarios 2 and 4 with DATA_WIDTH=16, ADDR_WIDTH=6, STRONY_WIDTH=3.

Source files
------------

// File: rtl/pamiec_pkg.sv
// Shared types and address helpers for the paged data memory.
package pamiec_pkg;

    typedef enum logic {
        BEZCZYNNY   = 1'b0,
        CZYSZCZENIE = 1'b1
    } stan_t;

    // TOP of a page: the page-select register address.
    function automatic int unsigned adr_strona(input int unsigned aw);
        return (32'd1 << aw) - 32'd1;
    endfunction

    // TOP-1 of a page: the status/command register address.
    function automatic int unsigned adr_status(input int unsigned aw);
        return adr_strona(aw) - 32'd1;
    endfunction

endpackage

// File: rtl/ram_strony.sv
// Flat page RAM: one synchronous write port, one asynchronous read port.
module ram_strony #(
    parameter int AW = 12,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pamiec_data_str.sv
// Paged CPU data memory with page/status registers at the top of each page
// and a background engine that fills a whole page with FILL.
module pamiec_data_str
    import pamiec_pkg::*;
#(
    parameter int                  ADDR_WIDTH   = 8,
    parameter int                  DATA_WIDTH   = 8,
    parameter int                  STRONY_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_mem,
    input  logic [ADDR_WIDTH-1:0]   adres,
    input  logic [DATA_WIDTH-1:0]   dane,
    output logic [DATA_WIDTH-1:0]   out,
    output logic [STRONY_WIDTH-1:0] strona,
    output logic                    zajety
);

    localparam int PAW = ADDR_WIDTH + STRONY_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] TOP     = ADDR_WIDTH'(adr_strona(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] STATUS  = ADDR_WIDTH'(adr_status(ADDR_WIDTH));
    localparam logic [ADDR_WIDTH-1:0] OSTATNI = STATUS - 1'b1;

    stan_t                   stan, stan_nxt;
    logic [ADDR_WIDTH-1:0]   licznik, licznik_nxt;
    logic [STRONY_WIDTH-1:0] page_clr, page_clr_nxt;
    logic [STRONY_WIDTH-1:0] strona_nxt;

    logic                    cpu_ram_we;
    logic                    ram_we;
    logic [PAW-1:0]          ram_waddr;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic [DATA_WIDTH-1:0]   ram_rdata;
    logic [DATA_WIDTH-1:0]   status;

    assign zajety     = (stan == CZYSZCZENIE);
    assign cpu_ram_we = wr_mem && (adres < STATUS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stan     <= BEZCZYNNY;
            licznik  <= '0;
            page_clr <= '0;
            strona   <= '0;
        end else begin
            stan     <= stan_nxt;
            licznik  <= licznik_nxt;
            page_clr <= page_clr_nxt;
            strona   <= strona_nxt;
        end
    end

    always_comb begin
        stan_nxt     = stan;
        licznik_nxt  = licznik;
        page_clr_nxt = page_clr;
        strona_nxt   = strona;
        if (wr_mem && adres == TOP) begin
            strona_nxt = dane[STRONY_WIDTH-1:0];
        end
        case (stan)
            BEZCZYNNY: begin
                if (wr_mem && adres == STATUS && dane[0]) begin
                    stan_nxt     = CZYSZCZENIE;
                    page_clr_nxt = strona;
                    licznik_nxt  = '0;
                end
            end
            CZYSZCZENIE: begin
                // Last clear write lands on TOP-2; the register words are never touched.
                if (licznik == OSTATNI) begin
                    stan_nxt    = BEZCZYNNY;
                    licznik_nxt = '0;
                end else begin
                    licznik_nxt = licznik + 1'b1;
                end
            end
            default: stan_nxt = BEZCZYNNY;
        endcase
    end

    // The clear engine owns the write port for its whole run; CPU writes are dropped.
    assign ram_we    = zajety ? 1'b1 : cpu_ram_we;
    assign ram_waddr = zajety ? {page_clr, licznik} : {strona, adres};
    assign ram_wdata = zajety ? FILL : dane;

    ram_strony #(
        .AW(PAW),
        .DW(DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr ({strona, adres}),
        .rdata (ram_rdata)
    );

    always_comb begin
        status                   = '0;
        status[DATA_WIDTH-1]     = zajety;
        status[STRONY_WIDTH-1:0] = page_clr;
    end

    always_comb begin
        out = ram_rdata;
        if (adres == TOP) begin
            out = wr_mem ? dane : DATA_WIDTH'(strona);
        end else if (adres == STATUS) begin
            out = status;
        end else if (wr_mem && !zajety) begin
            out = dane;
        end
    end

endmodule
